dnn_sched: RTL and testbench

Controller that sequences the two-layer DNN datapath (4→4 linear, ReLU, 4→2 linear; fixed-latency pipeline, no stall, no reset). It holds the 24 signed 5-bit weights in a writable register bank, accepts input vectors over a valid/ready stream, and issues them to the datapath. It tracks in-flight vectors with its own token pipeline and buffers results in an in-order FIFO with backpressure. It arbitrates between weight writes and vector issue so that weights never change while a vector is in flight.

---
 rtl/dnn_sched.sv | 144 ++++++++++++++
 tb/tb_dnn_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_sched.sv
// dnn_sched: issue/capture controller for the two-layer DNN datapath.
// Holds the 24-entry weight bank, issues input vectors, follows them with a
// token pipeline matched to the datapath latency, and buffers results in an
// in-order FIFO. A pending weight write stalls issue until the pipe drains,
// so weights are stable for every vector between issue and capture.
module dnn_sched #(
  parameter int I_W   = 7,
  parameter int PERF  = 2,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic signed [I_W-1:0] s_x0,
  input  logic signed [I_W-1:0] s_x1,
  input  logic signed [I_W-1:0] s_x2,
  input  logic signed [I_W-1:0] s_x3,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [4:0]            cfg_addr,
  input  logic signed [4:0]     cfg_data,
  output logic signed [I_W-1:0] dp_x0,
  output logic signed [I_W-1:0] dp_x1,
  output logic signed [I_W-1:0] dp_x2,
  output logic signed [I_W-1:0] dp_x3,
  output logic                  dp_in_ready,
  output logic signed [4:0]     dp_w04, dp_w05, dp_w06, dp_w07,
  output logic signed [4:0]     dp_w14, dp_w15, dp_w16, dp_w17,
  output logic signed [4:0]     dp_w24, dp_w25, dp_w26, dp_w27,
  output logic signed [4:0]     dp_w34, dp_w35, dp_w36, dp_w37,
  output logic signed [4:0]     dp_w48, dp_w49, dp_w58, dp_w59,
  output logic signed [4:0]     dp_w68, dp_w69, dp_w78, dp_w79,
  input  logic signed [I_W+12:0] dp_out0,
  input  logic signed [I_W+12:0] dp_out1,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic signed [I_W+12:0] m_out0,
  output logic signed [I_W+12:0] m_out1,
  output logic                  busy
);

  localparam int LAT = (PERF == 2) ? 6 : 3;
  localparam int OW  = I_W + 13;
  localparam int CW  = $clog2(DEPTH + LAT + 1) + 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  logic signed [4:0] r_w [24];
  logic [LAT-1:0]    r_tok;
  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     r_occ;
  logic [2*OW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  state_t            r_state;

  logic          w_fire;
  logic          w_cap;
  logic          w_pop;
  logic          w_cfg_acc;
  logic          w_credit;
  logic [CW-1:0] w_inflight_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit counts only registered occupancy: a same-cycle pop is not reused.
  assign w_credit       = (r_inflight + r_occ) < CW'(DEPTH);
  assign s_ready        = rst_n & ~cfg_valid & w_credit;
  assign cfg_ready      = rst_n & (r_state == S_IDLE);
  assign w_fire         = s_valid & s_ready;
  assign w_cfg_acc      = cfg_valid & cfg_ready;
  assign w_cap          = r_tok[LAT-1];
  assign m_valid        = (r_occ != '0);
  assign w_pop          = m_valid & m_ready;
  assign w_inflight_nxt = r_inflight + CW'(w_fire) - CW'(w_cap);
  assign busy           = (r_inflight != '0) | (r_occ != '0);

  assign dp_in_ready = w_fire;
  assign dp_x0 = s_x0;
  assign dp_x1 = s_x1;
  assign dp_x2 = s_x2;
  assign dp_x3 = s_x3;

  // Layer-1 weights: addr 4*i+j drives w{i}{4+j}
  assign dp_w04 = r_w[0];  assign dp_w05 = r_w[1];  assign dp_w06 = r_w[2];  assign dp_w07 = r_w[3];
  assign dp_w14 = r_w[4];  assign dp_w15 = r_w[5];  assign dp_w16 = r_w[6];  assign dp_w17 = r_w[7];
  assign dp_w24 = r_w[8];  assign dp_w25 = r_w[9];  assign dp_w26 = r_w[10]; assign dp_w27 = r_w[11];
  assign dp_w34 = r_w[12]; assign dp_w35 = r_w[13]; assign dp_w36 = r_w[14]; assign dp_w37 = r_w[15];
  // Layer-2 weights: addr 16+2*k+j drives w{4+k}{8+j}
  assign dp_w48 = r_w[16]; assign dp_w49 = r_w[17];
  assign dp_w58 = r_w[18]; assign dp_w59 = r_w[19];
  assign dp_w68 = r_w[20]; assign dp_w69 = r_w[21];
  assign dp_w78 = r_w[22]; assign dp_w79 = r_w[23];

  assign m_out0 = r_mem[r_rp][OW-1:0];
  assign m_out1 = r_mem[r_rp][2*OW-1:OW];

  // Weight bank: writes land only when the pipe is empty; addr 24..31 are sinks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 24; i++) r_w[i] <= '0;
    end else if (w_cfg_acc && (cfg_addr < 5'd24)) begin
      r_w[cfg_addr] <= cfg_data;
    end
  end

  // Token pipe mirrors datapath latency; state tracks the in-flight count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tok      <= '0;
      r_inflight <= '0;
      r_state    <= S_IDLE;
    end else begin
      r_tok      <= {r_tok[LAT-2:0], w_fire};
      r_inflight <= w_inflight_nxt;
      if (w_inflight_nxt == '0) r_state <= S_IDLE;
      else if (cfg_valid)       r_state <= S_DRAIN;
      else                      r_state <= S_RUN;
    end
  end

  // Result FIFO pointers and occupancy; push on token capture, pop on m handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else begin
      if (w_cap) r_wp <= ptr_inc(r_wp);
      if (w_pop) r_rp <= ptr_inc(r_rp);
      r_occ <= r_occ + CW'(w_cap) - CW'(w_pop);
    end
  end

  // Result storage; contents are meaningless unless counted in r_occ
  always_ff @(posedge clk) begin
    if (w_cap) r_mem[r_wp] <= {dp_out1, dp_out0};
  end

endmodule

// File: tb/tb_dnn_sched.sv
// Directed bench for dnn_sched with a behavioural 6-cycle datapath model.
module tb_dnn_sched;
  localparam int I_W = 7, PERF = 2, DEPTH = 8, LAT = 6, OW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, s_valid, s_ready, cfg_valid, cfg_ready, dp_in_ready, m_valid, m_ready, busy;
  logic signed [I_W-1:0] s_x0, s_x1, s_x2, s_x3, dp_x0, dp_x1, dp_x2, dp_x3;
  logic [4:0] cfg_addr;
  logic signed [4:0] cfg_data;
  logic signed [4:0] dp_w04, dp_w05, dp_w06, dp_w07, dp_w14, dp_w15, dp_w16, dp_w17;
  logic signed [4:0] dp_w24, dp_w25, dp_w26, dp_w27, dp_w34, dp_w35, dp_w36, dp_w37;
  logic signed [4:0] dp_w48, dp_w49, dp_w58, dp_w59, dp_w68, dp_w69, dp_w78, dp_w79;
  logic signed [OW-1:0] dp_out0, dp_out1, m_out0, m_out1;

  dnn_sched #(.I_W(I_W), .PERF(PERF), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_x0(s_x0), .s_x1(s_x1), .s_x2(s_x2), .s_x3(s_x3),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .dp_x0(dp_x0), .dp_x1(dp_x1), .dp_x2(dp_x2), .dp_x3(dp_x3), .dp_in_ready(dp_in_ready),
    .dp_w04(dp_w04), .dp_w05(dp_w05), .dp_w06(dp_w06), .dp_w07(dp_w07),
    .dp_w14(dp_w14), .dp_w15(dp_w15), .dp_w16(dp_w16), .dp_w17(dp_w17),
    .dp_w24(dp_w24), .dp_w25(dp_w25), .dp_w26(dp_w26), .dp_w27(dp_w27),
    .dp_w34(dp_w34), .dp_w35(dp_w35), .dp_w36(dp_w36), .dp_w37(dp_w37),
    .dp_w48(dp_w48), .dp_w49(dp_w49), .dp_w58(dp_w58), .dp_w59(dp_w59),
    .dp_w68(dp_w68), .dp_w69(dp_w69), .dp_w78(dp_w78), .dp_w79(dp_w79),
    .dp_out0(dp_out0), .dp_out1(dp_out1),
    .m_valid(m_valid), .m_ready(m_ready), .m_out0(m_out0), .m_out1(m_out1), .busy(busy)
  );

  // Datapath model: free-running, unresettable, fed from the weight ports
  logic signed [I_W-1:0] dx [4];
  logic signed [4:0] w1 [4][4];
  logic signed [4:0] w2 [4][2];
  assign dx[0] = dp_x0; assign dx[1] = dp_x1; assign dx[2] = dp_x2; assign dx[3] = dp_x3;
  assign w1[0][0] = dp_w04; assign w1[0][1] = dp_w05; assign w1[0][2] = dp_w06; assign w1[0][3] = dp_w07;
  assign w1[1][0] = dp_w14; assign w1[1][1] = dp_w15; assign w1[1][2] = dp_w16; assign w1[1][3] = dp_w17;
  assign w1[2][0] = dp_w24; assign w1[2][1] = dp_w25; assign w1[2][2] = dp_w26; assign w1[2][3] = dp_w27;
  assign w1[3][0] = dp_w34; assign w1[3][1] = dp_w35; assign w1[3][2] = dp_w36; assign w1[3][3] = dp_w37;
  assign w2[0][0] = dp_w48; assign w2[0][1] = dp_w49; assign w2[1][0] = dp_w58; assign w2[1][1] = dp_w59;
  assign w2[2][0] = dp_w68; assign w2[2][1] = dp_w69; assign w2[3][0] = dp_w78; assign w2[3][1] = dp_w79;

  int hv [4];
  int acc, o0, o1;
  always_comb begin
    hv = '{default: 0};
    acc = 0; o0 = 0; o1 = 0;
    for (int j = 0; j < 4; j++) begin
      acc = 0;
      for (int i = 0; i < 4; i++) acc += int'(dx[i]) * int'(w1[i][j]);
      hv[j] = (acc < 0) ? 0 : acc;
    end
    for (int k = 0; k < 4; k++) begin
      o0 += hv[k] * int'(w2[k][0]);
      o1 += hv[k] * int'(w2[k][1]);
    end
  end

  logic signed [OW-1:0] p0 [LAT];
  logic signed [OW-1:0] p1 [LAT];
  always @(posedge clk) begin
    p0[0] <= OW'(o0);
    p1[0] <= OW'(o1);
    for (int k = 1; k < LAT; k++) begin
      p0[k] <= p0[k-1];
      p1[k] <= p1[k-1];
    end
  end
  assign dp_out0 = p0[LAT-1];
  assign dp_out1 = p1[LAT-1];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    int n;
    n = 0;
    cfg_valid = 1'b1; cfg_addr = 5'(a); cfg_data = 5'(d);
    #1;
    while (!cfg_ready && n < 50) begin cyc(); n++; end
    if (n >= 50) chk("wr_timeout", 0, 1);
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_x0 = I_W'(a); s_x1 = I_W'(b); s_x2 = I_W'(c); s_x3 = I_W'(d);
    #1;
    while (!s_ready && n < 50) begin cyc(); n++; end
    if (n >= 50) chk("send_timeout", 0, 1);
    cyc();
    s_valid = 1'b0;
    // junk on the bus so a mistimed capture picks up wrong data
    s_x0 = -7'sd33; s_x1 = 7'sd17; s_x2 = -7'sd5; s_x3 = 7'sd29;
  endtask

  task automatic recv(input string tag, input longint e0, input longint e1);
    int n;
    n = 0;
    m_ready = 1'b1;
    while (!m_valid && n < 50) begin cyc(); n++; end
    if (n >= 50) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_out0"}, m_out0, e0);
    chk({tag, "_out1"}, m_out1, e1);
    cyc();
    m_ready = 1'b0;
  endtask

  task automatic set_l1(input int v);
    for (int a = 0; a < 16; a++) wr(a, v);
  endtask

  task automatic set_l2(input int v0, input int v1);
    for (int k = 0; k < 4; k++) begin wr(16 + 2*k, v0); wr(17 + 2*k, v1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1);
  end

  initial begin
    int k, r, n, bad, stale;
    logic f, p;
    rst_n = 1'b0; s_valid = 1'b1; m_ready = 1'b0; cfg_valid = 1'b0;
    cfg_addr = '0; cfg_data = '0;
    s_x0 = 7'sd1; s_x1 = 7'sd2; s_x2 = 7'sd3; s_x3 = 7'sd4;

    // reset state, with s_valid asserted to prove nothing issues
    repeat (3) cyc();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_dp_in_ready", dp_in_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w79", dp_w79, 0);
    s_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_cfg_ready", cfg_ready, 1);
    chk("post_rst_s_ready", s_ready, 1);

    // weight address map and out-of-range sink
    wr(5, 3);   chk("map_w15", dp_w15, 3);
    wr(19, -2); chk("map_w59", dp_w59, -2);
    wr(25, 7);
    chk("sink_w05", dp_w05, 0);
    chk("sink_w25", dp_w25, 0);
    chk("sink_w15", dp_w15, 3);

    // A: all-ones layer 1, +1/-1 layer 2, latency
    set_l1(1); set_l2(1, -1);
    send(1, 2, 3, 4);
    chk("a_dp_x_pass", dp_x1, 17);
    chk("a_busy", busy, 1);
    k = 0;
    while (!m_valid && k < 20) begin cyc(); k++; end
    chk("a_latency", k, 6);
    recv("a", 40, -40);
    chk("a_idle_busy", busy, 0);

    // B: negative hidden layer clipped by ReLU
    set_l1(-1);
    send(1, 2, 3, 4);
    recv("b", 0, 0);

    // C: extreme magnitudes
    set_l1(-16); set_l2(-16, -16);
    send(-64, -64, -64, -64);
    recv("c", -262144, -262144);

    // D: asymmetric weights expose map transposition; two back-to-back vectors
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) wr(4*i + j, (i <= j) ? 1 : 0);
    wr(16, 1); wr(17, 0); wr(18, 2); wr(19, 0);
    wr(20, 3); wr(21, 0); wr(22, 4); wr(23, 5);
    send(1, 2, 3, 4);
    send(1, -2, 3, 4);
    recv("d0", 65, 50);
    recv("d1", 31, 30);

    // E: backpressure, 10 offered with m_ready low; x=(v,0,0,0) -> (10v, 5v)
    s_x1 = '0; s_x2 = '0; s_x3 = '0;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      if (k < 10) begin s_valid = 1'b1; s_x0 = I_W'(k + 1); end else s_valid = 1'b0;
      #1;
      f = dp_in_ready;
      cyc();
      if (f) k++;
    end
    chk("e_accepted_full", k, 8);
    chk("e_s_ready_low", s_ready, 0);
    chk("e_m_valid", m_valid, 1);
    m_ready = 1'b1;
    r = 0;
    for (int c = 0; c < 100 && r < 10; c++) begin
      if (k < 10) begin s_valid = 1'b1; s_x0 = I_W'(k + 1); end else s_valid = 1'b0;
      #1;
      f = dp_in_ready;
      p = m_valid;
      if (p) begin
        chk("e_out0", m_out0, 10 * (r + 1));
        chk("e_out1", m_out1, 5 * (r + 1));
      end
      cyc();
      if (f) k++;
      if (p) r++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("e_drained", r, 10);
    chk("e_accepted_all", k, 10);

    // F: weight write arbitrates against 3 in-flight vectors
    send(1, 0, 0, 0);
    send(2, 0, 0, 0);
    send(3, 0, 0, 0);
    s_valid = 1'b1; s_x0 = 7'sd4; s_x1 = '0; s_x2 = '0; s_x3 = '0;
    cfg_valid = 1'b1; cfg_addr = 5'd16; cfg_data = 5'sd2;
    #1;
    chk("f_s_ready_drop", s_ready, 0);
    chk("f_cfg_ready_low", cfg_ready, 0);
    n = 0; bad = 0;
    while (!cfg_ready && n < 20) begin
      if (dp_in_ready) bad++;
      cyc(); n++;
    end
    chk("f_drain_cycles", n, 6);
    chk("f_no_issue", bad, 0);
    chk("f_issue_blocked", dp_in_ready, 0);
    cyc();
    cfg_valid = 1'b0;
    #1;
    chk("f_new_w48", dp_w48, 2);
    chk("f_s_ready_back", s_ready, 1);
    cyc();
    s_valid = 1'b0;
    recv("f1", 10, 5);
    recv("f2", 20, 10);
    recv("f3", 30, 15);
    recv("f4", 44, 20);

    // G: reset with 2 buffered and 4 in flight
    send(1, 0, 0, 0);
    send(2, 0, 0, 0);
    repeat (8) cyc();
    send(3, 0, 0, 0); send(4, 0, 0, 0); send(5, 0, 0, 0); send(6, 0, 0, 0);
    chk("g_pre_busy", busy, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("g_m_valid", m_valid, 0);
    chk("g_busy", busy, 0);
    chk("g_w48", dp_w48, 0);
    chk("g_w04", dp_w04, 0);
    m_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      if (m_valid) stale++;
      cyc();
    end
    m_ready = 1'b0;
    chk("g_no_stale", stale, 0);
    send(3, 1, 2, 1);
    recv("g_zero_w", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
